// File: rtl/mouse_pkg.sv
// Purpose : shared state encoding and PS/2 mouse protocol constants for the mouse master.
// Latency : n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mouse_pkg;

   typedef enum logic [3:0] {
      SEND_RST      = 4'd0,
      WAIT_SENT_RST = 4'd1,
      WAIT_ACK_RST  = 4'd2,
      WAIT_SELFTEST = 4'd3,
      WAIT_ID       = 4'd4,
      SEND_EN       = 4'd5,
      WAIT_SENT_EN  = 4'd6,
      WAIT_ACK_EN   = 4'd7,
      WAIT_STATUS   = 4'd8,
      WAIT_DX       = 4'd9,
      WAIT_DY       = 4'd10,
      PUBLISH       = 4'd11
   } master_state_t;

   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] RSP_ACK      = 8'hFA;
   localparam logic [7:0] RSP_SELFTEST = 8'hAA;
   localparam logic [7:0] RSP_ID       = 8'h00;

   // States in which the receiver is listening for a byte from the mouse.
   function automatic logic is_read_state(input master_state_t s);
      return (s == WAIT_ACK_RST) || (s == WAIT_SELFTEST) || (s == WAIT_ID) ||
             (s == WAIT_ACK_EN)  || (s == WAIT_STATUS)   || (s == WAIT_DX) ||
             (s == WAIT_DY);
   endfunction

endpackage

// File: rtl/mouse_timeout_ctr.sv
// Purpose : counts cycles spent in the current state; flags when the wait budget is used up.
// Latency : expire asserts in the TIMEOUT_CYCLES-th cycle after the last clear.
// Backpressure: none; saturates at the limit until cleared.
// Ports   : CLK, RESET (async active-low), clear (restart count), expire (limit reached).
module mouse_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input  logic CLK,
   input  logic RESET,
   input  logic clear,
   output logic expire
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         r_cnt <= '0;
      else if (clear)
         r_cnt <= '0;
      else if (r_cnt != LAST)
         r_cnt <= r_cnt + 1'b1;
   end

   // First cycle after a clear reads 0, so LAST is hit after exactly
   // TIMEOUT_CYCLES cycles in the same state.
   assign expire = (r_cnt == LAST);

endmodule

// File: rtl/mouse_master_fsm.sv
// Purpose : PS/2 mouse host controller: reset/enable handshake, then 3-byte packet capture and publish.
// Latency : MOUSE_* and SEND_INTERRUPT valid one cycle after the BYTE_READ of the DY byte.
// Backpressure: none; waits are bounded by TIMEOUT_CYCLES (WAIT_STATUS waits forever).
// Ports   : CLK/RESET (async active-low); SEND_BYTE/BYTE_TO_SEND/BYTE_SENT to the transmitter;
//           READ_ENABLE/BYTE_READ/BYTE_IN/BYTE_ERROR_CODE from the receiver;
//           MOUSE_STATUS/DX/DY + SEND_INTERRUPT published packet; MASTER_STATE debug.
module mouse_master_fsm
   import mouse_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input  logic       CLK,
   input  logic       RESET,
   output logic       SEND_BYTE,
   output logic [7:0] BYTE_TO_SEND,
   input  logic       BYTE_SENT,
   output logic       READ_ENABLE,
   input  logic       BYTE_READ,
   input  logic [7:0] BYTE_IN,
   input  logic [1:0] BYTE_ERROR_CODE,
   output logic [7:0] MOUSE_STATUS,
   output logic [7:0] MOUSE_DX,
   output logic [7:0] MOUSE_DY,
   output logic       SEND_INTERRUPT,
   output logic [3:0] MASTER_STATE
);

   master_state_t r_state, w_next;
   logic          w_read_en, w_rd, w_err, w_expire, w_load_out;
   logic          r_send_byte, r_send_int;
   logic [7:0]    r_byte_to_send, r_status_sh, r_dx_sh;
   logic [7:0]    r_status, r_dx, r_dy;

   assign w_read_en = is_read_state(r_state);
   assign w_rd      = BYTE_READ & w_read_en;
   assign w_err     = |BYTE_ERROR_CODE;

   mouse_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .CLK    (CLK),
      .RESET  (RESET),
      .clear  (w_next != r_state),
      .expire (w_expire)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         r_state <= SEND_RST;
      else
         r_state <= w_next;
   end

   // A received byte takes priority over a timeout in the same cycle.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         SEND_RST:      w_next = WAIT_SENT_RST;
         WAIT_SENT_RST: if (BYTE_SENT) w_next = WAIT_ACK_RST;
                        else if (w_expire) w_next = SEND_RST;
         WAIT_ACK_RST:  if (w_rd) w_next = (!w_err && BYTE_IN == RSP_ACK) ? WAIT_SELFTEST : SEND_RST;
                        else if (w_expire) w_next = SEND_RST;
         WAIT_SELFTEST: if (w_rd) w_next = (!w_err && BYTE_IN == RSP_SELFTEST) ? WAIT_ID : SEND_RST;
                        else if (w_expire) w_next = SEND_RST;
         WAIT_ID:       if (w_rd) w_next = (!w_err && BYTE_IN == RSP_ID) ? SEND_EN : SEND_RST;
                        else if (w_expire) w_next = SEND_RST;
         SEND_EN:       w_next = WAIT_SENT_EN;
         WAIT_SENT_EN:  if (BYTE_SENT) w_next = WAIT_ACK_EN;
                        else if (w_expire) w_next = SEND_RST;
         WAIT_ACK_EN:   if (w_rd) w_next = (!w_err && BYTE_IN == RSP_ACK) ? WAIT_STATUS : SEND_RST;
                        else if (w_expire) w_next = SEND_RST;
         // Bit 3 of a status byte is always 1; anything else is a misaligned byte.
         WAIT_STATUS:   if (w_rd && !w_err && BYTE_IN[3]) w_next = WAIT_DX;
         WAIT_DX:       if (w_rd) w_next = w_err ? WAIT_STATUS : WAIT_DY;
                        else if (w_expire) w_next = WAIT_STATUS;
         WAIT_DY:       if (w_rd) w_next = w_err ? WAIT_STATUS : PUBLISH;
                        else if (w_expire) w_next = WAIT_STATUS;
         PUBLISH:       w_next = WAIT_STATUS;
         default:       w_next = SEND_RST;
      endcase
   end

   // Outputs are loaded on the edge that enters PUBLISH, so they are visible
   // during the single PUBLISH cycle together with SEND_INTERRUPT.
   assign w_load_out = (r_state == WAIT_DY) && (w_next == PUBLISH);

   // Command pulse is registered one cycle behind SEND_RST/SEND_EN so that the
   // outputs are clean zeros while reset holds the FSM in SEND_RST.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_send_byte    <= 1'b0;
         r_byte_to_send <= 8'h00;
         r_status_sh    <= 8'h00;
         r_dx_sh        <= 8'h00;
         r_status       <= 8'h00;
         r_dx           <= 8'h00;
         r_dy           <= 8'h00;
         r_send_int     <= 1'b0;
      end else begin
         r_send_byte <= (r_state == SEND_RST) || (r_state == SEND_EN);
         if (r_state == SEND_RST) r_byte_to_send <= CMD_RESET;
         if (r_state == SEND_EN)  r_byte_to_send <= CMD_ENABLE;
         if (r_state == WAIT_STATUS && w_next == WAIT_DX) r_status_sh <= BYTE_IN;
         if (r_state == WAIT_DX && w_next == WAIT_DY)     r_dx_sh     <= BYTE_IN;
         if (w_load_out) begin
            r_status <= r_status_sh;
            r_dx     <= r_dx_sh;
            r_dy     <= BYTE_IN;
         end
         r_send_int <= w_load_out;
      end
   end

   assign SEND_BYTE      = r_send_byte;
   assign BYTE_TO_SEND   = r_byte_to_send;
   assign READ_ENABLE    = w_read_en;
   assign MOUSE_STATUS   = r_status;
   assign MOUSE_DX       = r_dx;
   assign MOUSE_DY       = r_dy;
   assign SEND_INTERRUPT = r_send_int;
   assign MASTER_STATE   = r_state;

endmodule

// File: doc/mouse_master_fsm.md
MOUSE_MASTER_FSM -- requirements
Module: mouse_master_fsm

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 5_000_000, max CLK cycles spent in any timed wait state (100 ms at 50 MHz).
REQ-002 SHALL have port: CLK  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: RESET  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: SEND_BYTE  out  1  one-cycle request to the PS/2 transmitter.
REQ-005 SHALL have port: BYTE_TO_SEND  out  8  command byte, held stable from SEND_BYTE until BYTE_SENT.
REQ-006 SHALL have port: BYTE_SENT  in  1  one-cycle transmit-complete pulse.
REQ-007 SHALL have port: READ_ENABLE  out  1  enables the PS/2 receiver.
REQ-008 SHALL have port: BYTE_READ  in  1  one-cycle pulse, BYTE_IN valid.
REQ-009 SHALL have port: BYTE_IN  in  8  received byte.
REQ-010 SHALL have port: BYTE_ERROR_CODE  in  2  non-zero = parity/stop error on the byte qualified by BYTE_READ.
REQ-011 SHALL have port: MOUSE_STATUS  out  8  packet byte 0 (YV, XV, YS, XS, 1, 0, R, L).
REQ-012 SHALL have port: MOUSE_DX  out  8  packet byte 1, two's-complement X delta.
REQ-013 SHALL have port: MOUSE_DY  out  8  packet byte 2, two's-complement Y delta.
REQ-014 SHALL have port: SEND_INTERRUPT  out  1  one-cycle pulse, new packet published.
REQ-015 SHALL have port: MASTER_STATE  out  4  current state encoding, for debug.

Function
REQ-016 SHALL implement states: SEND_RST, WAIT_SENT_RST, WAIT_ACK_RST, WAIT_SELFTEST, WAIT_ID, SEND_EN, WAIT_SENT_EN, WAIT_ACK_EN, WAIT_STATUS, WAIT_DX, WAIT_DY, PUBLISH.
REQ-017 SEND_RST SHALL drive BYTE_TO_SEND=0xFF and pulse SEND_BYTE for one cycle, then go to WAIT_SENT_RST.
REQ-018 WAIT_SENT_RST -> WAIT_ACK_RST on BYTE_SENT.
REQ-019 WAIT_ACK_RST -> WAIT_SELFTEST on byte 0xFA.
REQ-020 WAIT_SELFTEST -> WAIT_ID on byte 0xAA.
REQ-021 WAIT_ID -> SEND_EN on byte 0x00.
REQ-022 SEND_EN SHALL drive BYTE_TO_SEND=0xF4 and pulse SEND_BYTE for one cycle, then go to WAIT_SENT_EN.
REQ-023 WAIT_SENT_EN -> WAIT_ACK_EN on BYTE_SENT; WAIT_ACK_EN -> WAIT_STATUS on byte 0xFA.
REQ-024 During init, a wrong byte value or a non-zero BYTE_ERROR_CODE SHALL return the FSM to SEND_RST.
REQ-025 The timeout counter SHALL clear on every state change; reaching TIMEOUT_CYCLES in any init wait state, WAIT_DX or WAIT_DY SHALL trigger the timeout action; WAIT_STATUS SHALL never time out.
REQ-026 Timeout action: init wait states -> SEND_RST; WAIT_DX or WAIT_DY -> WAIT_STATUS, partial packet discarded.
REQ-027 WAIT_STATUS SHALL accept a byte only if BYTE_IN[3]=1 and error code=0; any other byte is dropped and the FSM stays (resync).
REQ-028 In WAIT_DX or WAIT_DY, a byte with non-zero error code SHALL discard the packet and return the FSM to WAIT_STATUS.
REQ-029 Accepted bytes SHALL be held in internal shadow registers; MOUSE_* outputs SHALL change only in PUBLISH, all three in the same cycle.
REQ-030 PUBLISH SHALL last exactly one cycle: load outputs from shadow registers, pulse SEND_INTERRUPT, then go to WAIT_STATUS.
REQ-031 Latency: DY byte accepted at BYTE_READ cycle N; outputs valid and SEND_INTERRUPT=1 at cycle N+1 registered output.
REQ-032 READ_ENABLE SHALL be 1 in every WAIT_ACK_*, WAIT_SELFTEST, WAIT_ID, WAIT_STATUS, WAIT_DX and WAIT_DY state, and 0 otherwise.
REQ-033 BYTE_READ SHALL be ignored when READ_ENABLE=0; BYTE_SENT SHALL be ignored outside WAIT_SENT_*.
REQ-034 Overflow bits SHALL pass through unmodified, with no clamping of DX or DY.

Reset
REQ-035 While RESET=0: state=SEND_RST, counter=0, SEND_BYTE=0, BYTE_TO_SEND=0x00, READ_ENABLE=0, MOUSE_STATUS=MOUSE_DX=MOUSE_DY=0x00, SEND_INTERRUPT=0.
REQ-036 Reset asserted mid-packet or mid-init SHALL abort immediately; after release, the init sequence SHALL restart from SEND_RST.

Structure
REQ-037 Package mouse_pkg SHALL hold the state enum and the constants CMD_RESET=0xFF, CMD_ENABLE=0xF4, RSP_ACK=0xFA, RSP_SELFTEST=0xAA and RSP_ID=0x00.
REQ-038 The timeout counter SHALL be a sub-module, mouse_timeout_ctr, with ports clear, expire and parameter TIMEOUT_CYCLES.

Verification
REQ-039 Reset release, model returns FA, AA, 00, then FA -> SEND_BYTE pulses carrying FF then F4; FSM reaches WAIT_STATUS.
REQ-040 Packet 0x09, 0x05, 0xFE -> STATUS=0x09, DX=0x05, DY=0xFE, exactly one SEND_INTERRUPT pulse, one cycle after the last BYTE_READ.
REQ-041 Byte 0xF0 (bit3=0) in WAIT_STATUS, then packet 0x18, 0x01, 0x02 -> only the second packet is published.
REQ-042 Byte 0xFC instead of 0xAA during init -> FSM returns to SEND_RST and FF is resent.
REQ-043 TIMEOUT_CYCLES=100 with no byte after the status byte -> after 100 cycles the FSM is in WAIT_STATUS and outputs are unchanged.
REQ-044 RESET pulsed low after the DX byte -> outputs=0x00, init restarts, no SEND_INTERRUPT pulse.
